// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Imported by the loader top and its byte assembler.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted stream bytes into 32-bit little-endian words.
// Serves both the header word and the program data words.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    // Newest byte enters at the top so byte 0 ends in lane 0.
    word      = {in_byte, shreg_q[31:8]};
    word_full = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d   = cnt_q + 2'd1;
      shreg_d = word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Host-stream loader: header word count, then program words
// written into instruction memory while the CPU is held.
module imem_loader
  import loader_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
  parameter int                       MEM_WORDS     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_byte,
  output logic                     in_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] waddr,
  output logic [ADDRESS_WIDTH-1:0] wdata,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  loader_state_t state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] k_q, k_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] wdata_q, wdata_d;

  logic        accept;
  logic        asm_clear;
  logic [31:0] asm_word;
  logic        asm_full;

  assign in_ready = (state_q == S_HDR) || (state_q == S_DATA);
  assign accept   = in_valid && in_ready;

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .accept    (accept),
    .in_byte   (in_byte),
    .word      (asm_word),
    .word_full (asm_full)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_HDR;
          k_d       = '0;
          addr_d    = BASE_ADDR;
          asm_clear = 1'b1;
        end
      end
      S_HDR: begin
        if (asm_full) begin
          n_d = asm_word;
          if (asm_word == 32'd0)
            state_d = S_DONE;
          else if (asm_word > 32'(MEM_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (asm_full) begin
          wdata_d = ADDRESS_WIDTH'(asm_word);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDRESS_WIDTH'(BYTES_PER_WORD);
        k_d    = k_q + 32'd1;
        if (k_q + 32'd1 == n_q)
          state_d = S_DONE;
        else
          state_d = S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we       = (state_q == S_WRITE);
  assign waddr    = addr_q;
  assign wdata    = wdata_q;
  assign busy     = (state_q == S_HDR) || (state_q == S_DATA)
                 || (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, empty and oversized
// headers, stalled streams and mid-session reset.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int          MW   = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(
    .ADDRESS_WIDTH (32),
    .BASE_ADDR     (BASE),
    .MEM_WORDS     (MW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int we_cnt    = 0;
  int ready_bad = 0;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      we_cnt++;
      if (in_ready !== 1'b0) ready_bad++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("byte_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic end_stream();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) chk("done_timeout", 32'(n), 32'd0);
  endtask

  logic [31:0] words[16];
  int          snap;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    // 1) reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_hold",  32'(cpu_hold), 32'd1);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_waddr", waddr,         BASE);
    chk("rst_wdata", wdata,         32'd0);
    chk("rst_we",    32'(we_cnt),   32'd0);

    // 2) two-word program, back-to-back bytes
    do_start();
    chk("t2_busy", 32'(busy), 32'd1);
    send_word(32'd2, 0);
    send_word(32'h00100513, 0);
    end_stream();
    chk("t2_we0",    32'(we), 32'd1);
    chk("t2_waddr0", waddr,   32'hBFC00000);
    chk("t2_wdata0", wdata,   32'h00100513);
    chk("t2_rdy0",   32'(in_ready), 32'd0);
    send_word(32'h00200593, 0);
    end_stream();
    chk("t2_we1",    32'(we), 32'd1);
    chk("t2_waddr1", waddr,   32'hBFC00004);
    chk("t2_wdata1", wdata,   32'h00200593);
    @(negedge clk);
    chk("t2_done", 32'(done),     32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd0);
    chk("t2_busy", 32'(busy),     32'd0);
    chk("t2_nwe",  32'(we_cnt),   32'd2);

    // 3) empty program
    snap = we_cnt;
    do_start();
    chk("t3_clr", 32'(done), 32'd0);
    send_word(32'd0, 0);
    end_stream();
    chk("t3_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("t3_nwe", 32'(we_cnt), 32'(snap));

    // 4) oversized header, then recovery
    do_start();
    send_word(32'(MW + 1), 0);
    end_stream();
    chk("t4_err",  32'(err),      32'd1);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    chk("t4_done", 32'(done),     32'd0);
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    @(negedge clk);
    chk("t4_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_nwe", 32'(we_cnt), 32'(snap));
    do_start();
    chk("t4_busy", 32'(busy),     32'd1);
    chk("t4_rdyh", 32'(in_ready), 32'd1);
    chk("t4_clr",  32'(err),      32'd0);
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 0);
    end_stream();
    chk("t4_wa", waddr, BASE);
    chk("t4_wd", wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t4_ok", 32'(done), 32'd1);

    // 5) 16 words with random stalls
    wa_q.delete();
    wd_q.delete();
    ready_bad = 0;
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    do_start();
    send_word(32'd16, 2);
    for (int i = 0; i < 16; i++) send_word(words[i], 3);
    end_stream();
    wait_done(50);
    chk("t5_done", 32'(done),        32'd1);
    chk("t5_nwe",  32'(wa_q.size()), 32'd16);
    chk("t5_rdy",  32'(ready_bad),   32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i < wa_q.size()) begin
        chk($sformatf("t5_wa%0d", i), wa_q[i], BASE + 32'(4 * i));
        chk($sformatf("t5_wd%0d", i), wd_q[i], words[i]);
      end
    end

    // 6) reset mid-word, then reload
    do_start();
    send_word(32'd5, 0);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    end_stream();
    repeat (2) @(negedge clk);
    snap = we_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'h66;
    repeat (8) @(negedge clk);
    chk("t6_nwe",   32'(we_cnt),   32'(snap));
    chk("t6_busy",  32'(busy),     32'd0);
    chk("t6_hold",  32'(cpu_hold), 32'd1);
    chk("t6_rdy",   32'(in_ready), 32'd0);
    chk("t6_waddr", waddr,         BASE);
    in_valid = 1'b0;
    wa_q.delete();
    wd_q.delete();
    do_start();
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 1);
    end_stream();
    wait_done(20);
    chk("t6_done", 32'(done),        32'd1);
    chk("t6_nwe2", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() > 0) begin
      chk("t6_wa", wa_q[0], BASE);
      chk("t6_wd", wd_q[0], 32'hCAFEF00D);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
